// File: rtl/kmeans_pkg.sv
// Shared definitions for the k-means iteration sequencer.
// Holds the FSM state encoding and a width helper.
package kmeans_pkg;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    localparam int num_states = 7;
    localparam int state_w = clog2(num_states);

    localparam logic [state_w-1:0] IDLE   = state_w'(0);
    localparam logic [state_w-1:0] CLEAR  = state_w'(1);
    localparam logic [state_w-1:0] STREAM = state_w'(2);
    localparam logic [state_w-1:0] DRAIN  = state_w'(3);
    localparam logic [state_w-1:0] UPDATE = state_w'(4);
    localparam logic [state_w-1:0] CHECK  = state_w'(5);
    localparam logic [state_w-1:0] DONE   = state_w'(6);

endpackage

// File: rtl/kmeans_iter_ctrl.sv
// Pass sequencer for the k-means datapath: clear, stream, drain,
// update, then decide between another pass and stopping.
module kmeans_iter_ctrl
    import kmeans_pkg::*;
#(
    parameter int input_data_qty_bit_width = 8,
    parameter int input_data_qty = 256,
    parameter int max_iter = 16,
    parameter int iter_bit_width = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic pipe_valid_out,
    input  logic pipe_changed,
    input  logic upd_done,
    output logic rd_en,
    output logic [input_data_qty_bit_width-1:0] rd_addr,
    output logic acc_clear,
    output logic upd_start,
    output logic busy,
    output logic done,
    output logic converged,
    output logic [iter_bit_width-1:0] iter_count
);

    localparam int aw = input_data_qty_bit_width;
    localparam int cnt_w = aw + 1;
    localparam logic [aw-1:0] last_addr = aw'(input_data_qty - 1);
    localparam logic [cnt_w-1:0] qty_cnt = cnt_w'(input_data_qty);
    localparam logic [iter_bit_width-1:0] iter_lim =
        iter_bit_width'(max_iter);

    logic [state_w-1:0] state;
    logic [cnt_w-1:0] out_cnt;
    logic chg;
    logic upd_first;
    logic counting;
    logic retire;
    logic [iter_bit_width-1:0] iter_next;

    assign counting = (state == STREAM) || (state == DRAIN);
    assign retire = counting && pipe_valid_out;
    assign iter_next = iter_count + 1'b1;

    assign rd_en = (state == STREAM);
    assign acc_clear = (state == CLEAR);
    assign upd_start = (state == UPDATE) && upd_first;
    assign busy = (state != IDLE) && (state != DONE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            rd_addr <= '0;
            out_cnt <= '0;
            chg <= 1'b0;
            upd_first <= 1'b0;
            iter_count <= '0;
            converged <= 1'b0;
        end else begin
            // Retirements may still land in STREAM while reads continue.
            if (retire) begin
                out_cnt <= out_cnt + 1'b1;
                if (pipe_changed) begin
                    chg <= 1'b1;
                end
            end
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= CLEAR;
                        iter_count <= '0;
                        converged <= 1'b0;
                    end
                end
                CLEAR: begin
                    out_cnt <= '0;
                    rd_addr <= '0;
                    chg <= (iter_count == '0);
                    state <= STREAM;
                end
                STREAM: begin
                    if (rd_addr == last_addr) begin
                        rd_addr <= '0;
                        state <= DRAIN;
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    if (out_cnt >= qty_cnt) begin
                        state <= UPDATE;
                        upd_first <= 1'b1;
                    end
                end
                UPDATE: begin
                    // A done seen while the trigger is still out is stale.
                    if (upd_first) begin
                        upd_first <= 1'b0;
                    end else if (upd_done) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    iter_count <= iter_next;
                    if (!chg) begin
                        state <= DONE;
                        converged <= 1'b1;
                    end else if (iter_next == iter_lim) begin
                        state <= DONE;
                    end else begin
                        state <= CLEAR;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
